// File: rtl/act_row_sequencer_if.sv
// Command/status bundle between the layer controller, activation buffer and PE
// and the activation-row sequencer.
interface act_row_sequencer_if #(
    parameter int ROW_W = 8,
    parameter int CNT_W = 5
);
    logic             layer_start;
    logic             mode;
    logic [ROW_W-1:0] cfg_num_rows;
    logic [CNT_W-1:0] row_val_num;
    logic             pe_ready;

    logic             act_start;
    logic             act_en;
    logic             act_row_cal_done;
    logic             act_row_index_count_3;
    logic             act_zero_flag;
    logic             act_state_nz;
    logic             pe_valid;
    logic [ROW_W-1:0] row_idx;
    logic             busy;
    logic             layer_done;

    modport master (
        output layer_start, mode, cfg_num_rows, row_val_num, pe_ready,
        input  act_start, act_en, act_row_cal_done, act_row_index_count_3, act_zero_flag,
               act_state_nz, pe_valid, row_idx, busy, layer_done
    );

    modport slave (
        input  layer_start, mode, cfg_num_rows, row_val_num, pe_ready,
        output act_start, act_en, act_row_cal_done, act_row_index_count_3, act_zero_flag,
               act_state_nz, pe_valid, row_idx, busy, layer_done
    );
endinterface

// File: rtl/act_row_sequencer.sv
// Row-level controller for the activation buffer: serial streaming (mode 0) or
// paced parallel rows with grouped index pulses (mode 1). All outputs are flops.
module act_row_sequencer #(
    parameter int ROW_W     = 8,
    parameter int CNT_W     = 5,
    parameter int FLAG_LAT  = 2,
    parameter int ROW_CYC   = 1,
    parameter int ROW_GROUP = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    act_row_sequencer_if.slave   bus
);
    localparam int LAT_W = (FLAG_LAT > 1) ? $clog2(FLAG_LAT) : 1;
    localparam int PAR_W = (ROW_CYC > 1) ? $clog2(ROW_CYC) : 1;
    localparam int GRP_W = (ROW_GROUP > 1) ? $clog2(ROW_GROUP) : 1;
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(FLAG_LAT - 1);
    localparam logic [PAR_W-1:0] PAR_LAST = PAR_W'(ROW_CYC - 1);
    localparam logic [GRP_W-1:0] GRP_LAST = GRP_W'(ROW_GROUP - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(16);

    typedef enum logic [2:0] {
        S_IDLE, S_PREP, S_WAIT, S_STREAM, S_PAR, S_ROWEND, S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic             mode_q, mode_d;
    logic [ROW_W-1:0] rows_q, rows_d;
    logic [ROW_W-1:0] row_idx_q, row_idx_d;
    logic [GRP_W-1:0] grp_q, grp_d;
    logic [LAT_W-1:0] lat_q, lat_d;
    logic [PAR_W-1:0] par_q, par_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             zero_q, zero_d;
    logic             start_q, start_d, en_q, en_d, cal_q, cal_d, c3_q, c3_d;
    logic             nz_q, nz_d, pv_q, pv_d, busy_q, busy_d, done_q, done_d;
    logic [CNT_W-1:0] val_clamped;
    logic             last_q, last_d;

    assign val_clamped = (bus.row_val_num > CNT_MAX) ? CNT_MAX : bus.row_val_num;
    assign last_q      = (row_idx_q == rows_q - ROW_W'(1));
    assign last_d      = (row_idx_d == rows_d - ROW_W'(1));

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        rows_d    = rows_q;
        row_idx_d = row_idx_q;
        grp_d     = grp_q;
        lat_d     = lat_q;
        par_d     = par_q;
        cnt_d     = cnt_q;
        zero_d    = zero_q;
        unique case (state_q)
            S_IDLE: if (bus.layer_start) begin
                mode_d = bus.mode;
                rows_d = bus.cfg_num_rows;
                if (bus.cfg_num_rows == '0) begin
                    state_d = S_DONE;
                end else begin
                    row_idx_d = '0;
                    grp_d     = '0;
                    lat_d     = '0;
                    state_d   = S_PREP;
                end
            end
            S_PREP: state_d = S_WAIT;
            S_WAIT: if (lat_q == LAT_LAST) begin
                cnt_d = val_clamped;
                par_d = '0;
                if (mode_q) begin
                    state_d = S_PAR;
                end else if (val_clamped == '0) begin
                    zero_d  = 1'b1;
                    state_d = S_ROWEND;
                end else begin
                    state_d = S_STREAM;
                end
            end else begin
                lat_d = lat_q + LAT_W'(1);
            end
            // cnt_q is >=1 on entry, so a decrement here can never wrap
            S_STREAM: if (bus.pe_ready) begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = S_ROWEND;
            end
            S_PAR: if (par_q == PAR_LAST) state_d = S_ROWEND;
                   else par_d = par_q + PAR_W'(1);
            S_ROWEND: begin
                zero_d = 1'b0;
                if (last_q) begin
                    state_d = S_DONE;
                end else begin
                    row_idx_d = row_idx_q + ROW_W'(1);
                    grp_d     = (grp_q == GRP_LAST) ? '0 : grp_q + GRP_W'(1);
                    lat_d     = '0;
                    state_d   = S_WAIT;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output flops are loaded from the next state so each pulse lines up with its state.
    always_comb begin
        start_d = (state_d == S_PREP);
        en_d    = (state_d == S_ROWEND) && mode_d && !last_d;
        cal_d   = (state_d == S_ROWEND) && !mode_d;
        c3_d    = (state_d == S_PAR) && (par_d == PAR_LAST) && ((grp_d == GRP_LAST) || last_d);
        nz_d    = (state_d == S_STREAM) || (state_d == S_PAR);
        pv_d    = (state_d == S_STREAM);
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            mode_q    <= 1'b0;
            rows_q    <= '0;
            row_idx_q <= '0;
            grp_q     <= '0;
            lat_q     <= '0;
            par_q     <= '0;
            cnt_q     <= '0;
            zero_q    <= 1'b0;
            start_q   <= 1'b0;
            en_q      <= 1'b0;
            cal_q     <= 1'b0;
            c3_q      <= 1'b0;
            nz_q      <= 1'b0;
            pv_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            rows_q    <= rows_d;
            row_idx_q <= row_idx_d;
            grp_q     <= grp_d;
            lat_q     <= lat_d;
            par_q     <= par_d;
            cnt_q     <= cnt_d;
            zero_q    <= zero_d;
            start_q   <= start_d;
            en_q      <= en_d;
            cal_q     <= cal_d;
            c3_q      <= c3_d;
            nz_q      <= nz_d;
            pv_q      <= pv_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.act_start             = start_q;
    assign bus.act_en                = en_q;
    assign bus.act_row_cal_done      = cal_q;
    assign bus.act_row_index_count_3 = c3_q;
    assign bus.act_zero_flag         = zero_q;
    assign bus.act_state_nz          = nz_q;
    assign bus.pe_valid              = pv_q;
    assign bus.row_idx               = row_idx_q;
    assign bus.busy                  = busy_q;
    assign bus.layer_done            = done_q;
endmodule
